// File: rtl/commit_trace_sched.sv
// commit_trace_sched: buffers multi-port commit records into a FIFO and serialises them onto a trace stream.
// Optional TRACE_TIMESTAMP_EN stores the capture cycle with each record and drives trace_cycle_o.
module commit_trace_sched #(
    parameter int unsigned NrPorts    = 2,
    parameter int unsigned FifoDepth  = 8,
    parameter logic [31:0] TohostAddr = 32'h8010_0000,
    parameter logic [63:0] CycleLimit = 64'd1000000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NrPorts-1:0]     commit_valid_i,
    input  logic [NrPorts*64-1:0]  commit_pc_i,
    input  logic [NrPorts*32-1:0]  commit_instr_i,
    input  logic [NrPorts*5-1:0]   commit_rd_i,
    input  logic [NrPorts-1:0]     commit_fpr_i,
    input  logic [NrPorts*64-1:0]  commit_wdata_i,
    input  logic [NrPorts-1:0]     commit_exc_i,
    input  logic [NrPorts*6-1:0]   commit_cause_i,
    input  logic                   host_we_i,
    input  logic [31:0]            host_addr_i,
    input  logic [63:0]            host_wdata_i,
    output logic                   trace_valid_o,
    input  logic                   trace_ready_i,
    output logic [1:0]             trace_port_o,
    output logic [63:0]            trace_pc_o,
    output logic [31:0]            trace_instr_o,
    output logic [4:0]             trace_rd_o,
    output logic                   trace_fpr_o,
    output logic [63:0]            trace_wdata_o,
    output logic                   trace_exc_o,
    output logic [5:0]             trace_cause_o,
    output logic [63:0]            trace_cycle_o,
    output logic [31:0]            drop_cnt_o,
    output logic [1:0]             state_o,
    output logic                   finish_o,
    output logic [63:0]            finish_code_o
);
    localparam int unsigned AW = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
    localparam int unsigned CW = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_e;

    typedef struct packed {
        logic [1:0]  port;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        fpr;
        logic [63:0] wdata;
        logic        exc;
        logic [5:0]  cause;
`ifdef TRACE_TIMESTAMP_EN
        logic [63:0] cycle;
`endif
    } rec_t;

    state_e        state_q, state_d;
    rec_t          mem_q [FifoDepth];
    rec_t          rec [NrPorts];
    rec_t          head;
    logic [AW-1:0] rd_q, wr_q;
    logic [AW-1:0] slot [NrPorts];
    logic [CW-1:0] count_q, count_d, space, n_enq;
    logic [2:0]    n_drop;
    logic [63:0]   cycle_q, code_q, code_d;
    logic [31:0]   drop_q, drop_d;
    logic [32:0]   drop_sum;
    logic [NrPorts-1:0] keep, write;
    logic          pop;

    // Records are ranked by ascending port so the lowest ports claim free slots first
    always_comb begin
        space  = CW'(FifoDepth) - count_q;
        n_enq  = '0;
        n_drop = '0;
        for (int p = 0; p < NrPorts; p++) begin
            keep[p]  = state_q == RUN && commit_valid_i[p] &&
                       !(commit_exc_i[p] && (commit_cause_i[p*6+:6] == 6'd2 || commit_cause_i[p*6+:6] == 6'd24));
            slot[p]  = wr_q + AW'(n_enq);
            write[p] = keep[p] && n_enq < space;
            n_enq    = n_enq + CW'(write[p]);
            n_drop   = n_drop + 3'(keep[p] && !write[p]);
            rec[p].port  = 2'(p);
            rec[p].pc    = commit_pc_i[p*64+:64];
            rec[p].instr = commit_instr_i[p*32+:32];
            rec[p].rd    = commit_rd_i[p*5+:5];
            rec[p].fpr   = commit_fpr_i[p];
            rec[p].wdata = commit_wdata_i[p*64+:64];
            rec[p].exc   = commit_exc_i[p];
            rec[p].cause = commit_cause_i[p*6+:6];
`ifdef TRACE_TIMESTAMP_EN
            rec[p].cycle = cycle_q;
`endif
        end
    end

    assign pop      = count_q != '0 && trace_ready_i;
    assign count_d  = count_q + n_enq - CW'(pop);
    assign drop_sum = {1'b0, drop_q} + 33'(n_drop);
    assign drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];

    // Tohost is checked first so it wins over a coincident timeout
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (state_q == RUN) begin
            if (host_we_i && host_addr_i == TohostAddr) begin
                state_d = DRAIN;
                code_d  = host_wdata_i;
            end else if (CycleLimit != '0 && cycle_q >= CycleLimit) begin
                state_d = DRAIN;
                code_d  = '1;
            end
        end else if (state_q == DRAIN && count_q == '0) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            cycle_q <= '0;
            code_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_q + AW'(pop);
            wr_q    <= wr_q + AW'(n_enq);
            count_q <= count_d;
            cycle_q <= cycle_q + 64'd1;
            code_q  <= code_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NrPorts; p++)
            if (write[p]) mem_q[slot[p]] <= rec[p];
    end

    assign trace_valid_o = count_q != '0;
    assign head          = trace_valid_o ? mem_q[rd_q] : '0;
    assign trace_port_o  = head.port;
    assign trace_pc_o    = head.pc;
    assign trace_instr_o = head.instr;
    assign trace_rd_o    = head.rd;
    assign trace_fpr_o   = head.fpr;
    assign trace_wdata_o = head.wdata;
    assign trace_exc_o   = head.exc;
    assign trace_cause_o = head.cause;
`ifdef TRACE_TIMESTAMP_EN
    assign trace_cycle_o = head.cycle;
`else
    assign trace_cycle_o = '0;
`endif
    assign drop_cnt_o    = drop_q;
    assign state_o       = state_q;
    assign finish_o      = state_q == DONE;
    assign finish_code_o = code_q;
endmodule

// File: tb/tb_commit_trace_sched.sv
// tb_commit_trace_sched: directed stimulus with a scoreboard queue checked by an independent trace monitor.
module tb_commit_trace_sched;
    typedef struct packed {
        logic [1:0]  port;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] wdata;
        logic        exc;
        logic [5:0]  cause;
    } exp_t;

    logic clk = 0, rst = 1, rst2 = 1;
    always #5 clk = ~clk;

    logic [1:0]   cv = '0, cfpr = '0, cexc = '0;
    logic [127:0] cpc = '0, cwd = '0;
    logic [63:0]  cinstr = '0;
    logic [9:0]   crd = '0;
    logic [11:0]  ccause = '0;
    logic         hwe = 0, rdy = 0;
    logic [31:0]  haddr = '0;
    logic [63:0]  hwd = '0;

    logic        tv, tfpr, texc, fin;
    logic [1:0]  tport, st;
    logic [63:0] tpc, twd, tcyc, code;
    logic [31:0] tinstr, drop;
    logic [4:0]  trd;
    logic [5:0]  tcause;

    logic        t_tv, t_fpr, t_exc, t_fin;
    logic [1:0]  t_port, t_st;
    logic [63:0] t_pc, t_wd, t_cyc, t_code;
    logic [31:0] t_instr, t_drop;
    logic [4:0]  t_rd;
    logic [5:0]  t_cause;

    exp_t sb[$];
    int n_tests = 0, n_fail = 0;

    commit_trace_sched u_dut (
        .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_pc_i(cpc), .commit_instr_i(cinstr),
        .commit_rd_i(crd), .commit_fpr_i(cfpr), .commit_wdata_i(cwd), .commit_exc_i(cexc),
        .commit_cause_i(ccause), .host_we_i(hwe), .host_addr_i(haddr), .host_wdata_i(hwd),
        .trace_valid_o(tv), .trace_ready_i(rdy), .trace_port_o(tport), .trace_pc_o(tpc),
        .trace_instr_o(tinstr), .trace_rd_o(trd), .trace_fpr_o(tfpr), .trace_wdata_o(twd),
        .trace_exc_o(texc), .trace_cause_o(tcause), .trace_cycle_o(tcyc), .drop_cnt_o(drop),
        .state_o(st), .finish_o(fin), .finish_code_o(code)
    );

    commit_trace_sched #(.CycleLimit(64'd100)) u_tmo (
        .clk_i(clk), .rst_i(rst2), .commit_valid_i(2'b00), .commit_pc_i(128'd0), .commit_instr_i(64'd0),
        .commit_rd_i(10'd0), .commit_fpr_i(2'b00), .commit_wdata_i(128'd0), .commit_exc_i(2'b00),
        .commit_cause_i(12'd0), .host_we_i(1'b0), .host_addr_i(32'd0), .host_wdata_i(64'd0),
        .trace_valid_o(t_tv), .trace_ready_i(1'b1), .trace_port_o(t_port), .trace_pc_o(t_pc),
        .trace_instr_o(t_instr), .trace_rd_o(t_rd), .trace_fpr_o(t_fpr), .trace_wdata_o(t_wd),
        .trace_exc_o(t_exc), .trace_cause_o(t_cause), .trace_cycle_o(t_cyc), .drop_cnt_o(t_drop),
        .state_o(t_st), .finish_o(t_fin), .finish_code_o(t_code)
    );

    task automatic chk(input string nm, input logic [168:0] act, input logic [168:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one port for the next edge; exp says whether the record should reach the trace stream
    task automatic put(input int p, input logic [63:0] pc, input logic exc, input logic [5:0] cause, input logic exp);
        logic [31:0] ins;
        ins = pc[31:0] ^ 32'hA5A5_0013;
        cv[p] = 1'b1;
        cpc[p*64+:64] = pc;
        cinstr[p*32+:32] = ins;
        cwd[p*64+:64] = ~pc;
        crd[p*5+:5] = pc[6:2];
        cfpr[p] = pc[3];
        cexc[p] = exc;
        ccause[p*6+:6] = cause;
        if (exp) sb.push_back('{port: 2'(p), pc: pc, instr: ins, wdata: ~pc, exc: exc, cause: cause});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        cv = '0;
        cexc = '0;
        hwe = 0;
    endtask

    task automatic drain;
        rdy = 1;
        for (int i = 0; i < 30 && tv; i++) step;
        chk("drain_valid", tv, 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (tv && rdy) begin
            if (sb.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("rec", {tport, tpc, tinstr, twd, texc, tcause}, sb.pop_front());
        end
    end

    initial begin
        #12 rst = 0;
        chk("rst_state", st, 0);
        chk("rst_valid", tv, 0);
        chk("rst_drop", drop, 0);
        chk("rst_finish", fin, 0);
        chk("rst_code", code, 0);
        chk("rst_cycle", tcyc, 0);
        @(posedge clk); #1;
        // 1: single commit, one-cycle latency
        rdy = 1;
        put(0, 64'h8000_0000, 0, 0, 1);
        step;
        chk("t1_valid", tv, 1);
        chk("t1_pc", tpc, 64'h8000_0000);
        chk("t1_port", tport, 0);
        step;
        chk("t1_empty", tv, 0);
        // 2: overflow with sink stalled
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            put(0, 64'h1000 + 64'(i * 16), 0, 0, i < 4);
            put(1, 64'h1008 + 64'(i * 16), 0, 0, i < 4);
            step;
        end
        chk("t2_drop", drop, 2);
        chk("t2_head_pc", tpc, 64'h1000);
        step;
        chk("t2_hold_pc", tpc, 64'h1000);
        drain;
        // 3: 7 queued, 2 arrive, 1 pops: no credit for the pop
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            put(0, 64'h2000 + 64'(i * 16), 0, 0, 1);
            put(1, 64'h2008 + 64'(i * 16), 0, 0, 1);
            step;
        end
        put(0, 64'h2100, 0, 0, 1);
        step;
        rdy = 1;
        put(0, 64'h2200, 0, 0, 1);
        put(1, 64'h2208, 0, 0, 0);
        step;
        chk("t3_drop", drop, 3);
        drain;
        // filtered exceptions: causes 2 and 24 vanish, other causes pass
        put(0, 64'h3000, 1, 6'd2, 0);
        put(1, 64'h3008, 1, 6'd24, 0);
        step;
        chk("filt_valid", tv, 0);
        chk("filt_drop", drop, 3);
        put(0, 64'h3010, 1, 6'd5, 1);
        put(1, 64'h3018, 1, 6'd24, 0);
        step;
        put(0, 64'h3020, 0, 6'd2, 1);
        step;
        drain;
        chk("filt_drop2", drop, 3);
        // 4: tohost store; transition-cycle commit still enqueued, DRAIN commits ignored
        rdy = 0;
        put(0, 64'h4000, 0, 0, 1);
        put(1, 64'h4008, 0, 0, 1);
        step;
        put(0, 64'h4010, 0, 0, 1);
        hwe = 1; haddr = 32'h8010_0000; hwd = 64'h1;
        step;
        chk("t4_state_drain", st, 1);
        chk("t4_code", code, 64'h1);
        chk("t4_finish_low", fin, 0);
        rdy = 1;
        put(0, 64'h4100, 0, 0, 0);
        put(1, 64'h4108, 0, 0, 0);
        step;
        for (int i = 0; i < 20 && st != 2; i++) step;
        chk("t4_state_done", st, 2);
        chk("t4_finish", fin, 1);
        chk("t4_code_done", code, 64'h1);
        chk("t4_drop", drop, 3);
        chk("t4_sb_empty", sb.size(), 0);
        put(0, 64'h4200, 0, 0, 0);
        hwe = 1; hwd = 64'h99;
        step;
        chk("t4_done_valid", tv, 0);
        chk("t4_done_code", code, 64'h1);
        chk("t4_done_state", st, 2);
        // async reset in DONE clears sticky outputs at once
        rst = 1;
        #1;
        chk("rst_done_finish", fin, 0);
        chk("rst_done_drop", drop, 0);
        chk("rst_done_code", code, 0);
        chk("rst_done_state", st, 0);
        #1 rst = 0;
        // 6: reset pulsed in DRAIN
        step;
        rdy = 0;
        put(0, 64'h5000, 0, 0, 1);
        put(1, 64'h5008, 0, 0, 1);
        hwe = 1; hwd = 64'h55;
        step;
        chk("t6_drain", st, 1);
        chk("t6_valid_pre", tv, 1);
        #2 rst = 1;
        #1;
        sb.delete();
        chk("t6_state", st, 0);
        chk("t6_valid", tv, 0);
        chk("t6_pc", tpc, 0);
        chk("t6_code", code, 0);
        chk("t6_finish", fin, 0);
        #1 rst = 0;
        // 5: cycle-limit timeout at counter value 100
        @(posedge clk); #1;
        rst2 = 0;
        for (int i = 0; i < 100; i++) step;
        chk("t5_run_at_100", t_st, 0);
        step;
        chk("t5_drain", t_st, 1);
        chk("t5_code", t_code, 64'hFFFF_FFFF_FFFF_FFFF);
        step;
        chk("t5_done", t_st, 2);
        chk("t5_finish", t_fin, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
